// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state encoding and width helper for the serializer family
package serializer_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/ser_lane_mux.sv
// ser_lane_mux: LANES:1 combinational lane selector over a packed word
module ser_lane_mux #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int IDX_W = 2
) (
  input  logic [LANES*WIDTH-1:0] data,
  input  logic [IDX_W-1:0]       idx,
  output logic [WIDTH-1:0]       lane
);
  // pick the lane whose position matches idx; out-of-range idx yields zero
  always_comb begin
    lane = '0;
    for (int k = 0; k < LANES; k++) lane = (idx == IDX_W'(k)) ? data[k*WIDTH +: WIDTH] : lane;
  end
endmodule

// File: rtl/serializer_stream.sv
// serializer_stream: LANES x WIDTH word to WIDTH-bit lane stream with per-word frame length
module serializer_stream
  import serializer_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int LANES = 4,
  localparam int IDX_W = clog2(LANES)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [LANES*WIDTH-1:0] I,
  input  logic                   I_VALID,
  output logic                   I_READY,
  input  logic [IDX_W-1:0]       I_LEN,
  output logic [WIDTH-1:0]       O,
  output logic                   O_VALID,
  input  logic                   O_READY,
  output logic                   O_LAST,
  output logic [IDX_W-1:0]       O_IDX
);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(LANES - 1);
  state_t                 state, state_nx;
  logic [IDX_W-1:0]       idx, idx_nx, len, len_nx, len_in;
  logic [LANES*WIDTH-1:0] lane_buf, lane_buf_nx;
  logic [WIDTH-1:0]       lane;
  logic                   accept, xfer, last;
  ser_lane_mux #(.WIDTH(WIDTH), .LANES(LANES), .IDX_W(IDX_W)) u_mux (
    .data(lane_buf),
    .idx (idx),
    .lane(lane)
  );
  assign last    = idx == len;
  assign O_VALID = state == ST_SEND;
  assign I_READY = ~RESET & ((state == ST_IDLE) | (O_VALID & O_READY & last));
  assign accept  = I_VALID & I_READY;
  assign xfer    = O_VALID & O_READY;
  assign len_in  = (I_LEN > MAX_IDX) ? MAX_IDX : I_LEN;
  assign O       = O_VALID ? lane : '0;
  assign O_IDX   = O_VALID ? idx : '0;
  assign O_LAST  = O_VALID & last;
  // a new word always restarts at lane 0; otherwise advance or retire the frame on transfer
  always_comb begin
    state_nx    = accept ? ST_SEND : (xfer & last) ? ST_IDLE : state;
    idx_nx      = accept ? '0 : (xfer & ~last) ? idx + 1'b1 : idx;
    len_nx      = accept ? len_in : len;
    lane_buf_nx = accept ? I : lane_buf;
  end
  // frame state registers, cleared immediately on reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      idx      <= '0;
      len      <= '0;
      lane_buf <= '0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      len      <= len_nx;
      lane_buf <= lane_buf_nx;
    end
  end
endmodule

// File: tb/tb_serializer_stream.sv
// tb_serializer_stream: queue-model random and directed bench for serializer_stream
module tb_serializer_stream;
  logic        CLK = 0, RESET = 1;
  logic [63:0] I = '0;
  logic        I_VALID = 0, I_READY, O_READY = 0, O_VALID, O_LAST;
  logic [1:0]  I_LEN = '0, O_IDX;
  logic [15:0] O;
  logic [23:0] i1 = '0;
  logic        v1 = 0, rdy1, ordy1 = 1, ov1, ol1;
  logic [1:0]  len1 = '0, oi1;
  logic [7:0]  o1;
  int n_checks = 0, n_errors = 0;
  typedef struct { logic [15:0] d; int idx; logic last; } lane_t;
  lane_t q[$];

  serializer_stream u0 (.CLK(CLK), .RESET(RESET), .I(I), .I_VALID(I_VALID), .I_READY(I_READY),
    .I_LEN(I_LEN), .O(O), .O_VALID(O_VALID), .O_READY(O_READY), .O_LAST(O_LAST), .O_IDX(O_IDX));
  serializer_stream #(.WIDTH(8), .LANES(3)) u1 (.CLK(CLK), .RESET(RESET), .I(i1), .I_VALID(v1),
    .I_READY(rdy1), .I_LEN(len1), .O(o1), .O_VALID(ov1), .O_READY(ordy1), .O_LAST(ol1), .O_IDX(oi1));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock of u0: drive, compare against the lane queue, then advance the queue
  task automatic cycle(input logic iv, input logic [63:0] w, input logic [1:0] ln, input logic ordy);
    logic exp_rdy;
    @(negedge CLK);
    I_VALID = iv; I = w; I_LEN = ln; O_READY = ordy;
    #1;
    exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
    check("i_ready", I_READY, exp_rdy);
    check("o_valid", O_VALID, q.size() != 0);
    if (q.size() != 0) begin
      check("o_data", O, q[0].d);
      check("o_idx", O_IDX, q[0].idx);
      check("o_last", O_LAST, q[0].last);
      if (ordy) void'(q.pop_front());
    end else begin
      check("idle_o", {O, O_IDX, O_LAST}, 0);
    end
    if (iv && exp_rdy)
      for (int k = 0; k <= int'(ln); k++) q.push_back('{w[k*16 +: 16], k, k == int'(ln)});
  endtask

  task automatic drain();
    repeat (6) cycle(0, 0, 0, 1);
    check("drained", q.size(), 0);
  endtask

  // one u1 frame: expected lane count is I_LEN+1 clamped to the 3 available lanes
  task automatic u1_frame(input logic [23:0] w, input logic [1:0] ln);
    int n;
    n = (ln > 2) ? 3 : int'(ln) + 1;
    @(negedge CLK);
    v1 = 1; i1 = w; len1 = ln;
    #1 check("u1_rdy", rdy1, 1);
    @(negedge CLK);
    v1 = 0; i1 = '1;
    for (int k = 0; k < n; k++) begin
      #1;
      check("u1_valid", ov1, 1);
      check("u1_data", o1, w[k*8 +: 8]);
      check("u1_idx", oi1, k);
      check("u1_last", ol1, k == n - 1);
      @(negedge CLK);
    end
    #1 check("u1_done", ov1, 0);
  endtask

  initial begin
    logic [63:0] a, b;
    #2;
    check("rst_ovalid", O_VALID, 0);
    check("rst_iready", I_READY, 0);
    check("rst_out", {O, O_IDX, O_LAST}, 0);
    check("rst_u1", {ov1, rdy1, o1}, 0);
    @(negedge CLK); @(negedge CLK);
    RESET = 0;
    cycle(1, 64'h4444_3333_2222_1111, 3, 1);
    drain();
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    for (int c = 0; c < 8; c++) cycle(1, c == 0 ? a : c == 4 ? b : {$urandom, $urandom}, 3, 1);
    drain();
    cycle(1, {$urandom, $urandom}, 3, 1);
    foreach (a[i]) if (i < 7) cycle(1, {$urandom, $urandom}, 3, (i == 1 || i == 2) ? 1'b0 : 1'b1);
    drain();
    cycle(1, {$urandom, $urandom}, 0, 1);
    cycle(1, {$urandom, $urandom}, 1, 1);
    drain();
    cycle(1, 64'hdddd_cccc_bbbb_aaaa, 3, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    @(negedge CLK);
    #1 check("pre_rst_idx", O_IDX, 2);
    check("pre_rst_data", O, 16'hcccc);
    #1 RESET = 1;
    #1;
    check("async_ovalid", O_VALID, 0);
    check("async_out", {O, O_IDX, O_LAST}, 0);
    check("async_iready", I_READY, 0);
    q.delete();
    @(negedge CLK);
    RESET = 0;
    #1 check("post_rst_iready", I_READY, 1);
    cycle(1, 64'h8888_7777_6666_5555, 3, 1);
    drain();
    u1_frame(24'hcc_bb_aa, 3);
    u1_frame(24'h33_22_11, 0);
    u1_frame(24'h66_55_44, 1);
    u1_frame(24'h99_88_77, 2);
    repeat (3000) cycle($urandom_range(0, 2) != 0, {$urandom, $urandom}, 2'($urandom), $urandom_range(0, 3) != 0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/serializer_stream.md
Name: serializer_stream

Overview:
Parametrised N-lane to 1-lane serializer, successor to the fixed 4x16 free-running serializer. It accepts one parallel word of LANES x WIDTH bits through a valid/ready handshake and emits lanes 0..len in order on a single WIDTH-bit valid/ready stream. Frame length is selectable per word, and O_LAST marks the final lane. It sits between wide datapath stages and narrow links, and tolerates back-pressure on both sides.

Parameters:
WIDTH, 16, bits per lane.
LANES, 4, lanes per input word; legal range 2..256.
IDX_W, derived localparam = clog2(LANES), lane-index width (not overridable).

Ports:
CLK  input  1  clock, all state on rising edge.
RESET  input  1  asynchronous, active-high reset.
I  input  LANES*WIDTH  parallel word; lane k = I[k*WIDTH +: WIDTH].
I_VALID  input  1  I and I_LEN valid.
I_READY  output  1  block can accept a word this cycle.
I_LEN  input  IDX_W  number of lanes to emit minus 1; sampled on accept.
O  output  WIDTH  current serial lane.
O_VALID  output  1  O, O_LAST and O_IDX valid.
O_READY  input  1  downstream accepts O this cycle.
O_LAST  output  1  current lane is lane len of the frame.
O_IDX  output  IDX_W  index of the lane currently on O.

Behaviour:
- One clock, CLK. RESET is asynchronous and active-high; all registers clear immediately on assertion.
- Reset values: state=IDLE, idx=0, len=0, lane buffer all-zero, O_VALID=0, O=0, O_LAST=0, O_IDX=0, I_READY=0 while RESET is high.
- States:
  - IDLE: no frame held.
  - SEND: frame held, O_VALID=1.
- Accept: fires when I_VALID & I_READY. Captures all LANES lanes of I into the buffer. len <= min(I_LEN, LANES-1); an out-of-range I_LEN clamps to LANES-1. idx <= 0. state <= SEND.
- I_READY = (state==IDLE) | (state==SEND & O_READY & idx==len). This is a combinational path from O_READY and is intentional, for zero-bubble back-to-back frames.
- In SEND: O = buffer[idx], O_IDX = idx, O_LAST = (idx==len).
- In IDLE: O, O_IDX and O_LAST are driven 0.
- Lane transfer: fires when O_VALID & O_READY.
  - If idx<len: idx <= idx+1.
  - If idx==len and an accept fires the same cycle: reload the buffer, idx <= 0, remain in SEND.
  - If idx==len and no accept: state <= IDLE.
- O_VALID=1 with O_READY=0: O, O_IDX and O_LAST hold stable; buffer and idx unchanged. I_VALID/I changes are ignored while I_READY=0.
- Latency: word accepted on edge t; lane 0 is visible on O after edge t (cycle t+1).
- Throughput: len+1 cycles per frame with continuous I_VALID and O_READY; no idle cycle between frames.
- len=0: single-lane frame, O_LAST=1 on lane 0.
- Only lanes 0..len are emitted; upper lanes are captured but never driven.
- RESET mid-frame: frame discarded, O_VALID drops asynchronously, no partial-frame resume.
- Idle accept and lane transfer cannot collide (O_VALID=0 in IDLE).

Decomposition:
- Shared package serializer_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_SEND=1'b1;
  - a clog2 constant function used for IDX_W.
- One natural sub-module: ser_lane_mux, a parametrised LANES:1 WIDTH-bit combinational mux indexed by idx. It is reused by future deserializer/debug blocks.
- FSM, buffer and handshake logic stay in serializer_stream.

Test Plan:
- Reset, then I=0x4444_3333_2222_1111 (LANES=4, WIDTH=16), I_LEN=3, I_VALID one cycle, O_READY=1 -> O = 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles, O_IDX 0..3, O_LAST only with 0x4444, then O_VALID=0.
- Two words back-to-back, I_VALID held, O_READY=1 -> second word accepted on the O_LAST cycle, 8 consecutive valid lanes, no bubble, I_READY high only on cycles 0 and 4.
- O_READY toggled 1,0,0,1 during a frame -> O/O_IDX stable while stalled, no lane lost or duplicated, I_READY stays 0 until the last lane transfers.
- I_LEN=0 and I_LEN=1 frames -> 1 and 2 lanes emitted respectively, O_LAST on idx 0 and 1; with LANES=3, I_LEN=3 -> clamped, 3 lanes emitted.
- RESET asserted asynchronously mid-frame at idx=2 -> O_VALID, O, O_IDX go 0 without a clock edge; after release, I_READY=1 and the next frame starts at lane 0.
- Parameter sweep WIDTH=8/LANES=8 and WIDTH=32/LANES=2 with random handshake -> scoreboard matches lane order and O_LAST positions.
